// File: rtl/t_block_xfer_ctrl_if.sv
// Bus bundle for the T-file block transfer sequencer: issue command, memory port, T file ports, issue-side Tjk path.
// Optional abort/aborted pair exists only when T_XFER_ABORT_EN is defined.
interface t_block_xfer_ctrl_if #(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 6,
    parameter int AWIDTH   = 24
);
    logic                start;
    logic                dir;
    logic [LOGDEPTH-1:0] jk;
    logic [6:0]          count;
    logic [AWIDTH-1:0]   base;
    logic                busy;
    logic                done;

    logic                mem_req;
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [WIDTH-1:0]    mem_rdata;

    logic [LOGDEPTH-1:0] rf_rd_addr;
    logic [WIDTH-1:0]    rf_rd_data;
    logic                rf_wr_en;
    logic [LOGDEPTH-1:0] rf_wr_addr;
    logic [WIDTH-1:0]    rf_wr_data;

    logic [LOGDEPTH-1:0] s_rd_addr;
    logic                s_wr_en;
    logic [LOGDEPTH-1:0] s_wr_addr;
    logic [WIDTH-1:0]    s_wr_data;
    logic                s_wr_ready;

`ifdef T_XFER_ABORT_EN
    logic                abort;
    logic                aborted;
`endif

    modport master (
`ifdef T_XFER_ABORT_EN
        output abort,
        input  aborted,
`endif
        output start, dir, jk, count, base,
        input  busy, done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata,
        input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        output rf_rd_data,
        output s_rd_addr, s_wr_en, s_wr_addr, s_wr_data,
        input  s_wr_ready
    );

    modport slave (
`ifdef T_XFER_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  start, dir, jk, count, base,
        output busy, done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata,
        output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rf_rd_data,
        input  s_rd_addr, s_wr_en, s_wr_addr, s_wr_data,
        output s_wr_ready
    );
endinterface

// File: rtl/t_block_xfer_ctrl.sv
// Block load/store sequencer between memory and the 64-entry T file; loads stream one word/cycle, stores take >=2 cycles/word.
// Requests held until mem_ack; issue-side T writes stalled during loads. Optional abort: define T_XFER_ABORT_EN.
module t_block_xfer_ctrl #(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 6,
    parameter int AWIDTH   = 24
) (
    input  logic clk,
    input  logic rst,
    t_block_xfer_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LD_REQ, LD_DRAIN, ST_RD, ST_REQ, DONE} state_t;

    localparam logic [6:0] DEPTH_CNT = 7'(2 ** LOGDEPTH);

    state_t              state, state_nx;
    logic [6:0]          n_r, req_cnt, ret_cnt, n_eff;
    logic [LOGDEPTH-1:0] jk_r;
    logic [AWIDTH-1:0]   base_r;
    logic [WIDTH-1:0]    wdata_r;
    logic                fresh_r, zero_r;
    logic                req_ack, ret_wr, abort_now;

    assign n_eff = (bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;

`ifdef T_XFER_ABORT_EN
    logic abort_r;

    assign abort_now   = bus.abort | abort_r;
    assign bus.aborted = (state == DONE) && abort_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_r <= 1'b0;
        end else if (state == IDLE) begin
            abort_r <= 1'b0;
        end else if (state != DONE && bus.abort) begin
            abort_r <= 1'b1;
        end
    end
`else
    assign abort_now = 1'b0;
`endif

    // A zero-length command still visits DONE for its pulse but never looks busy.
    assign bus.busy = (state != IDLE) && !zero_r;
    assign bus.done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            n_r     <= '0;
            req_cnt <= '0;
            ret_cnt <= '0;
            jk_r    <= '0;
            base_r  <= '0;
            wdata_r <= '0;
            fresh_r <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            fresh_r <= (state == ST_RD);
            if (state == IDLE && bus.start) begin
                n_r     <= n_eff;
                jk_r    <= bus.jk;
                base_r  <= bus.base;
                req_cnt <= '0;
                ret_cnt <= '0;
                zero_r  <= (n_eff == 7'd0);
            end else begin
                if (req_ack) req_cnt <= req_cnt + 7'd1;
                if (ret_wr)  ret_cnt <= ret_cnt + 7'd1;
            end
            if (fresh_r) wdata_r <= bus.rf_rd_data;
        end
    end

    always_comb begin
        state_nx       = state;
        req_ack        = 1'b0;
        ret_wr         = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.rf_rd_addr = bus.s_rd_addr;
        bus.rf_wr_en   = bus.s_wr_en;
        bus.rf_wr_addr = bus.s_wr_addr;
        bus.rf_wr_data = bus.s_wr_data;
        bus.s_wr_ready = 1'b1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (n_eff == 7'd0)  state_nx = DONE;
                    else if (bus.dir)   state_nx = ST_RD;
                    else                state_nx = LD_REQ;
                end
            end
            LD_REQ, LD_DRAIN: begin
                bus.s_wr_ready = 1'b0;
                ret_wr         = bus.mem_rvalid;
                bus.rf_wr_en   = bus.mem_rvalid;
                bus.rf_wr_addr = jk_r + ret_cnt[LOGDEPTH-1:0];
                bus.rf_wr_data = bus.mem_rdata;
                if (state == LD_REQ) begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = base_r + AWIDTH'(req_cnt);
                    req_ack      = bus.mem_ack;
                    // An ack in the abort cycle is still owed its return.
                    if (abort_now) begin
                        if (ret_cnt + 7'(ret_wr) == req_cnt + 7'(req_ack)) state_nx = DONE;
                        else                                                state_nx = LD_DRAIN;
                    end else if (req_ack && (req_cnt + 7'd1 == n_r)) begin
                        state_nx = LD_DRAIN;
                    end
                end else if (ret_wr && (ret_cnt + 7'd1 == req_cnt)) begin
                    state_nx = DONE;
                end
            end
            ST_RD: begin
                bus.rf_rd_addr = jk_r + req_cnt[LOGDEPTH-1:0];
                state_nx       = abort_now ? DONE : ST_REQ;
            end
            ST_REQ: begin
                bus.rf_rd_addr = jk_r + req_cnt[LOGDEPTH-1:0];
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = base_r + AWIDTH'(req_cnt);
                bus.mem_wdata  = fresh_r ? bus.rf_rd_data : wdata_r;
                req_ack        = bus.mem_ack;
                if (req_ack) begin
                    if (abort_now || (req_cnt + 7'd1 == n_r)) state_nx = DONE;
                    else                                      state_nx = ST_RD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_t_block_xfer_ctrl.sv
// Randomized bench: the bench plays T file and memory, and checks each transfer against address/index arithmetic.
`timescale 1ns/1ps
module tb_t_block_xfer_ctrl;
    localparam int WIDTH = 64, LOGDEPTH = 6, AWIDTH = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    t_block_xfer_ctrl_if #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .AWIDTH(AWIDTH)) bus ();
    t_block_xfer_ctrl #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed { logic [31:0] due; logic [63:0] data; } ret_t;
    typedef struct packed { logic [23:0] addr; logic [63:0] data; } acc_t;
    typedef struct packed { logic [5:0] idx; logic [63:0] data; } rfw_t;

    int n_vec = 0, n_err = 0;
    logic [63:0] tfile [64];
    logic [63:0] rd_pend = '0;
    int cyc = 0;
    ret_t ret_q [$];
    acc_t st_q [$];
    acc_t ld_q [$];
    rfw_t rfw_q [$];
    int done_cnt, done_cyc, busy_cnt, last_wr_cyc, last_ack_cyc, last_due;
    int rdy_low_cnt, iss_cnt, iss_first, run_steps;
    int ack_pct = 100, ack_delay = 0, ret_lat = 0, wait_cnt = 0;
    localparam logic [63:0] ISS_DATA = 64'hDEAD_BEEF_0000_0009;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [23:0] a);
        return {16'hA5C3, a, a ^ 24'h5A5A5A};
    endfunction

    // One clock: drive memory/RF responses at negedge, then sample and record the cycle's events.
    task automatic step();
        ret_t r;
        int due;
        @(negedge clk);
        cyc++;
        run_steps++;
        bus.rf_rd_data = rd_pend;
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
            if (wait_cnt >= ack_delay && $urandom_range(99) < ack_pct) begin
                bus.mem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        if (ret_q.size() > 0 && int'(ret_q[0].due) <= cyc) begin
            r = ret_q.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = r.data;
        end
        #1;
        if (bus.done) begin done_cnt++; done_cyc = cyc; end
        if (bus.busy) busy_cnt++;
        if (!bus.s_wr_ready) rdy_low_cnt++;
        if (bus.rf_wr_en) begin
            tfile[bus.rf_wr_addr] = bus.rf_wr_data;
            if (bus.s_wr_en && bus.rf_wr_addr == bus.s_wr_addr && bus.rf_wr_data == bus.s_wr_data) begin
                iss_cnt++;
                if (iss_first < 0) iss_first = cyc;
            end else begin
                rfw_q.push_back({bus.rf_wr_addr, bus.rf_wr_data});
                last_wr_cyc = cyc;
            end
        end
        rd_pend = tfile[bus.rf_rd_addr];
        if (bus.mem_req && bus.mem_ack) begin
            last_ack_cyc = cyc;
            if (bus.mem_we) begin
                st_q.push_back({bus.mem_addr, bus.mem_wdata});
            end else begin
                ld_q.push_back({bus.mem_addr, 64'd0});
                due = cyc + 1 + ret_lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                ret_q.push_back({32'(due), mem_word(bus.mem_addr)});
            end
        end
    endtask

    task automatic clear_run();
        ret_q.delete(); st_q.delete(); ld_q.delete(); rfw_q.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; last_wr_cyc = -1; last_ack_cyc = -1;
        last_due = 0; rdy_low_cnt = 0; iss_cnt = 0; iss_first = -1; run_steps = 0; wait_cnt = 0;
    endtask

    task automatic run_xfer(input string tag, input logic dir, input logic [5:0] jk,
                            input logic [6:0] count, input logic [23:0] base, input bit iss);
        logic [63:0] snap [64];
        int n, start_cyc, k, m;
        logic [23:0] ea;
        n = (count > 7'd64) ? 64 : int'(count);
        snap = tfile;
        clear_run();
        bus.s_wr_en = iss; bus.s_wr_addr = 6'd9; bus.s_wr_data = ISS_DATA;
        bus.dir = dir; bus.jk = jk; bus.count = count; bus.base = base; bus.start = 1'b1;
        start_cyc = cyc;
        step();
        bus.start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin step(); k++; end
        repeat (3) step();
        chk({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        if (n == 0) begin
            chk({tag, ".done_at"}, 64'(done_cyc), 64'(start_cyc + 1));
            chk({tag, ".busy_cnt"}, 64'(busy_cnt), 64'd0);
            chk({tag, ".mem_reqs"}, 64'(ld_q.size() + st_q.size()), 64'd0);
            chk({tag, ".rf_wrs"}, 64'(rfw_q.size()), 64'd0);
        end else begin
            chk({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(done_cyc - start_cyc));
            if (!dir) begin
                chk({tag, ".ld_reqs"}, 64'(ld_q.size()), 64'(n));
                chk({tag, ".rf_wrs"}, 64'(rfw_q.size()), 64'(n));
                chk({tag, ".st_reqs"}, 64'(st_q.size()), 64'd0);
                m = (rfw_q.size() < ld_q.size()) ? rfw_q.size() : ld_q.size();
                if (m > n) m = n;
                for (int i = 0; i < m; i++) begin
                    ea = base + 24'(i);
                    chk($sformatf("%s.ld_addr%0d", tag, i), 64'(ld_q[i].addr), 64'(ea));
                    chk($sformatf("%s.rf_idx%0d", tag, i), 64'(rfw_q[i].idx), 64'(6'(jk + 6'(i))));
                    chk($sformatf("%s.rf_dat%0d", tag, i), rfw_q[i].data, mem_word(ea));
                end
                chk({tag, ".done_after_wr"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
                if (iss) begin
                    chk({tag, ".rdy_low"}, 64'(rdy_low_cnt), 64'(done_cyc - start_cyc - 1));
                    chk({tag, ".iss_after_done"}, 64'(iss_first >= done_cyc), 64'd1);
                end
            end else begin
                chk({tag, ".st_reqs"}, 64'(st_q.size()), 64'(n));
                chk({tag, ".rf_wrs"}, 64'(rfw_q.size()), 64'd0);
                m = (st_q.size() < n) ? st_q.size() : n;
                for (int i = 0; i < m; i++) begin
                    ea = base + 24'(i);
                    chk($sformatf("%s.st_addr%0d", tag, i), 64'(st_q[i].addr), 64'(ea));
                    chk($sformatf("%s.st_dat%0d", tag, i), st_q[i].data, snap[6'(jk + 6'(i))]);
                end
                chk({tag, ".done_after_ack"}, 64'(done_cyc), 64'(last_ack_cyc + 1));
                if (iss) begin
                    chk({tag, ".rdy_low"}, 64'(rdy_low_cnt), 64'd0);
                    chk({tag, ".iss_every_cycle"}, 64'(iss_cnt), 64'(run_steps));
                end
            end
        end
        bus.s_wr_en = 1'b0;
    endtask

    initial begin
        int k;
        logic [6:0] cnt;
        logic [23:0] base;
        bus.start = 0; bus.dir = 0; bus.jk = '0; bus.count = '0; bus.base = '0;
        bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.rf_rd_data = '0;
        bus.s_rd_addr = '0; bus.s_wr_en = 0; bus.s_wr_addr = '0; bus.s_wr_data = '0;
`ifdef T_XFER_ABORT_EN
        bus.abort = 1'b0;
`endif
        for (int i = 0; i < 64; i++) tfile[i] = {$urandom, $urandom};
        clear_run();
        #1;
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst.mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst.rf_wr_en", 64'(bus.rf_wr_en), 64'd0);
        chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        ack_pct = 100; ack_delay = 0; ret_lat = 0;
        run_xfer("ld62", 1'b0, 6'd62, 7'd4, 24'h000100, 1'b0);
        ack_delay = 2;
        run_xfer("st5", 1'b1, 6'd5, 7'd3, 24'h000200, 1'b0);
        ack_delay = 0;
        run_xfer("zero", 1'b0, 6'd7, 7'd0, 24'h000400, 1'b0);
        run_xfer("ld100", 1'b0, 6'd10, 7'd100, 24'hFFFFFE, 1'b0);
        run_xfer("st100", 1'b1, 6'd33, 7'd100, 24'hFFFFFE, 1'b0);
        ret_lat = 2;
        run_xfer("ld_iss", 1'b0, 6'd20, 7'd6, 24'h000500, 1'b1);
        ret_lat = 0; ack_delay = 1;
        run_xfer("st_iss", 1'b1, 6'd5, 7'd3, 24'h000600, 1'b1);
        ack_delay = 0;

        // Reset in the middle of an 8-word load.
        clear_run();
        bus.dir = 1'b0; bus.jk = 6'd0; bus.count = 7'd8; bus.base = 24'h000300; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0;
        while (rfw_q.size() < 2 && k < 100) begin step(); k++; end
        chk("rstmid.two_returns", 64'(rfw_q.size()), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_word(24'h000302);
        #1;
        chk("rstmid.busy", 64'(bus.busy), 64'd0);
        chk("rstmid.mem_req", 64'(bus.mem_req), 64'd0);
        chk("rstmid.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rstmid.rf_wr_en", 64'(bus.rf_wr_en), 64'd0);
        chk("rstmid.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.rvalid_ignored", 64'(bus.rf_wr_en), 64'd0);
        clear_run();
        ret_q.push_back({32'(cyc + 1), mem_word(24'h000303)});
        repeat (4) step();
        chk("rstmid.no_done", 64'(done_cnt), 64'd0);
        chk("rstmid.no_rf_wr", 64'(rfw_q.size()), 64'd0);

        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(9);
            if (k == 0)      cnt = 7'd0;
            else if (k == 1) cnt = 7'($urandom_range(127, 65));
            else             cnt = 7'($urandom_range(24, 1));
            base = ($urandom_range(3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(15)) : 24'($urandom);
            ack_pct = $urandom_range(100, 30);
            ack_delay = $urandom_range(2);
            ret_lat = $urandom_range(3);
            run_xfer($sformatf("rnd%0d", t), 1'($urandom_range(1)), 6'($urandom), cnt, base, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
